gx4000_cpr_loader: RTL
======================

# gx4000_cpr_loader

Sequencer for GX4000/Plus cartridge (.CPR) loading. It sits between the file-loading byte stream and cartridge memory. It walks the RIFF/AMS! container, decodes each `cbNN` chunk into a 16 KB bank, and issues one memory write request per payload byte with a req/ack handshake. It reports which banks were populated, plus completion and error status, to the cartridge mapper.

## Interface
Parameters:
- NUM_BANKS, 32: highest accepted bank number is NUM_BANKS-1; sets `bank_valid` width.
- BANK_BYTES, 16384: per-bank payload limit; sets the `mem_addr` offset field (14 bits).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- file_load  in  1  high for the duration of a cartridge download.
- file_wr  in  1  one-cycle strobe: `file_data` valid at `file_addr`.
- file_addr  in  25  byte offset within the file.
- file_data  in  8  file byte.
- file_wait  out  1  back-pressure; high while a memory write is pending.
- mem_req  out  1  write request; held until acknowledged.
- mem_addr  out  19  {bank[4:0], offset[13:0]}.
- mem_data  out  8  byte to write.
- mem_ack  in  1  memory accepted the request this cycle.
- bank_valid  out  NUM_BANKS  bit n set once any byte of bank n has been written.
- load_busy  out  1  parse in progress.
- load_done  out  1  one-cycle pulse at end of a load.
- load_error  out  1  level; malformed file detected.

## Operation
- Reset: all outputs 0, state IDLE, byte counter 0.
- A load starts on a rising edge of `file_load`. The block clears `bank_valid` and `load_error`, sets `load_busy`, and enters RIFF_HDR with expected address 0.
- Every accepted `file_wr` must carry `file_addr` equal to the expected address, which increments per byte. A mismatch goes to ERROR.
- RIFF_HDR (12 bytes):
  - Bytes 0-3 must be "RIFF" (52 49 46 46).
  - Bytes 4-7 hold the little-endian size; it is ignored.
  - Bytes 8-11 must be "AMS!" (41 4D 53 21).
  - Any mismatch goes to ERROR at the offending byte. Otherwise go to CHUNK_HDR.
- CHUNK_HDR (8 bytes): a 4-byte ID, then a 32-bit little-endian size, latched as `remaining`.
  - The ID is a cart chunk if it is 'c','b' followed by two ASCII decimal digits forming a value < NUM_BANKS.
  - Cart chunk: go to CHUNK_DATA with bank latched and offset 0.
  - Any other ID: go to SKIP.
  - Size 0: go directly to PAD or CHUNK_HDR.
- CHUNK_DATA: each byte decrements `remaining`.
  - If offset < BANK_BYTES: raise `mem_req` with `mem_addr` = {bank, offset} and `mem_data` = byte, then increment offset.
  - Bytes at offset >= BANK_BYTES are consumed without a write (truncation, not an error).
- SKIP: consume `remaining` bytes with no writes.
- PAD: after a chunk with an odd size, consume one pad byte with no write. Then go to CHUNK_HDR.
- `bank_valid[bank]` is set on the acknowledged write of a bank's first byte.
- Falling edge of `file_load`:
  - From CHUNK_HDR with 0 header bytes consumed, or from DONE: pulse `load_done` and return to IDLE.
  - From any other parsing state: set `load_error`, pulse `load_done`, return to IDLE.
- ERROR: set `load_error`, drop `load_busy`, ignore bytes. On the fall of `file_load`, pulse `load_done` and return to IDLE.
- `file_wr` while `file_load` is low: ignored.

## Timing
- A `file_wr` in cycle N produces `mem_req` in cycle N+1, with `mem_addr`/`mem_data` stable until the acknowledge.
- Transfer completes in the first cycle where `mem_req` and `mem_ack` are both high. `mem_req` drops the next cycle; `file_wait` drops in the same cycle as that drop.
- `file_wait` goes high in cycle N+1, combinationally with `mem_req`. The upstream loader must not strobe `file_wr` while `file_wait` is high. A strobe arriving during `file_wait` anyway is dropped and sets `load_error`.
- Header bytes are consumed at 1 byte/cycle, with no memory request and no `file_wait`.
- `mem_ack` while `mem_req` is low: ignored.
- Reset mid-load or mid-request: `mem_req` is deasserted immediately and state returns to IDLE. The rest of that download is ignored until `file_load` falls and rises again.
- `load_done` is high for exactly one cycle, 1 cycle after the `file_load` fall.

## Test plan
- Valid file "RIFF"+size+"AMS!", then chunk "cb00" size 4 with data 11 22 33 44 and `mem_ack` tied high -> 4 requests to addresses 0x00000-0x00003 with data 11,22,33,44; `bank_valid` = 0x1; `load_done` pulse; `load_error` = 0.
- Chunk "cb05" size 3 followed by "cb31" size 2 -> writes at 0x14000-0x14002 and 0x7C000-0x7C001; the pad byte produces no write; `bank_valid` = 0x80000020.
- Chunk "fmt " size 6, then "cb40" size 2, then "cb01" size 1 -> only one write, at 0x04000; `bank_valid` = 0x2.
- Byte 9 = 'X' instead of 'M' -> ERROR, no writes, `load_error` = 1, `load_done` pulse after `file_load` falls.
- `mem_ack` delayed 3 cycles per request -> `mem_req`/`mem_addr`/`mem_data` stable for 4 cycles, `file_wait` high throughout. A strobe injected while waiting sets `load_error` and is not written.
- Reset asserted during the second data byte of "cb02" -> `mem_req` = 0 next cycle, all outputs 0, and subsequent bytes are ignored until `file_load` toggles. A chunk "cb03" of 16386 bytes in a later load -> exactly 16384 writes, ending at 0x0FFFF.

Source files
------------

// File: rtl/gx4000_cpr_loader.sv
// GX4000/Plus .CPR loader: walks the RIFF "AMS!" container from the download
// stream and turns each cbNN chunk into byte writes for one cartridge bank.
module gx4000_cpr_loader #(
    parameter int NUM_BANKS  = 32,
    parameter int BANK_BYTES = 16384,
    localparam int BANK_W    = $clog2(NUM_BANKS),
    localparam int OFF_W     = $clog2(BANK_BYTES)
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    file_load,
    input  logic                    file_wr,
    input  logic [24:0]             file_addr,
    input  logic [7:0]              file_data,
    output logic                    file_wait,
    output logic                    mem_req,
    output logic [BANK_W+OFF_W-1:0] mem_addr,
    output logic [7:0]              mem_data,
    input  logic                    mem_ack,
    output logic [NUM_BANKS-1:0]    bank_valid,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    load_error
);
    typedef enum logic [2:0] {
        IDLE, RIFF_HDR, CHUNK_HDR, CHUNK_DATA, SKIP, PAD, ERROR
    } state_t;

    state_t state, next_state;

    logic              load_q, load_rise, load_fall;
    logic              parsing, wr_seen, addr_ok, byte_acc, byte_bad, fall_err;
    logic [24:0]       exp_addr;
    logic [3:0]        hdr_cnt;
    logic [3:0][7:0]   id_b;
    logic [2:0][7:0]   size_b;
    logic [31:0]       remaining, size_full;
    logic              odd_size;
    logic [BANK_W-1:0] bank;
    logic [OFF_W:0]    offset;
    logic [7:0]        dig_hi, dig_lo, bank_num;
    logic              riff_ok, cart_id;

    assign load_rise = file_load & ~load_q;
    assign load_fall = ~file_load & load_q;
    assign parsing   = (state != IDLE) && (state != ERROR);
    assign wr_seen   = file_wr & file_load & parsing;
    assign addr_ok   = (file_addr == exp_addr);
    // A strobe while a write is outstanding is a protocol violation, never data.
    assign byte_acc  = wr_seen & ~file_wait & addr_ok;
    assign byte_bad  = wr_seen & (file_wait | ~addr_ok);

    assign size_full = {file_data, size_b[2], size_b[1], size_b[0]};
    assign dig_hi    = id_b[2] - 8'h30;
    assign dig_lo    = id_b[3] - 8'h30;
    assign bank_num  = dig_hi * 8'd10 + dig_lo;
    assign cart_id   = (id_b[0] == 8'h63) && (id_b[1] == 8'h62) &&
                       (dig_hi < 8'd10) && (dig_lo < 8'd10) &&
                       ({24'd0, bank_num} < 32'(NUM_BANKS));

    always_comb begin
        riff_ok = 1'b1;
        case (hdr_cnt)
            4'd0:    riff_ok = (file_data == 8'h52);
            4'd1:    riff_ok = (file_data == 8'h49);
            4'd2:    riff_ok = (file_data == 8'h46);
            4'd3:    riff_ok = (file_data == 8'h46);
            4'd8:    riff_ok = (file_data == 8'h41);
            4'd9:    riff_ok = (file_data == 8'h4D);
            4'd10:   riff_ok = (file_data == 8'h53);
            4'd11:   riff_ok = (file_data == 8'h21);
            default: riff_ok = 1'b1;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        fall_err   = 1'b0;
        if (load_fall) begin
            if (state != IDLE) next_state = IDLE;
            fall_err = parsing && !(state == CHUNK_HDR && hdr_cnt == 4'd0);
        end else begin
            case (state)
                IDLE: if (load_rise) next_state = RIFF_HDR;
                ERROR: next_state = ERROR;
                default: begin
                    if (byte_bad) begin
                        next_state = ERROR;
                    end else if (byte_acc) begin
                        case (state)
                            RIFF_HDR: begin
                                if (!riff_ok)               next_state = ERROR;
                                else if (hdr_cnt == 4'd11)  next_state = CHUNK_HDR;
                            end
                            CHUNK_HDR: begin
                                if (hdr_cnt == 4'd7) begin
                                    if (size_full == 32'd0) next_state = CHUNK_HDR;
                                    else if (cart_id)       next_state = CHUNK_DATA;
                                    else                    next_state = SKIP;
                                end
                            end
                            CHUNK_DATA, SKIP: begin
                                if (remaining == 32'd1) next_state = odd_size ? PAD : CHUNK_HDR;
                            end
                            PAD: next_state = CHUNK_HDR;
                            default: next_state = state;
                        endcase
                    end
                end
            endcase
        end
    end

    always_comb begin
        load_busy = parsing;
        file_wait = mem_req;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            load_q     <= 1'b1;   // a download already in flight must fall before it can restart
            exp_addr   <= '0;
            hdr_cnt    <= '0;
            id_b       <= '0;
            size_b     <= '0;
            remaining  <= '0;
            odd_size   <= 1'b0;
            bank       <= '0;
            offset     <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            bank_valid <= '0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            load_q    <= file_load;
            load_done <= load_fall && (state != IDLE);

            if (mem_req && mem_ack) begin
                mem_req <= 1'b0;
                if (mem_addr[OFF_W-1:0] == '0)
                    bank_valid[mem_addr[BANK_W+OFF_W-1 -: BANK_W]] <= 1'b1;
            end

            if (state == IDLE && load_rise) begin
                bank_valid <= '0;
                load_error <= 1'b0;
                exp_addr   <= '0;
                hdr_cnt    <= '0;
            end

            if (fall_err || (next_state == ERROR && state != ERROR))
                load_error <= 1'b1;

            if (byte_acc) begin
                exp_addr <= exp_addr + 25'd1;
                case (state)
                    RIFF_HDR: hdr_cnt <= (hdr_cnt == 4'd11) ? 4'd0 : hdr_cnt + 4'd1;
                    CHUNK_HDR: begin
                        hdr_cnt <= (hdr_cnt == 4'd7) ? 4'd0 : hdr_cnt + 4'd1;
                        if (hdr_cnt < 4'd4) begin
                            id_b[hdr_cnt[1:0]] <= file_data;
                        end else if (hdr_cnt < 4'd7) begin
                            size_b[hdr_cnt[1:0]] <= file_data;
                        end else begin
                            remaining <= size_full;
                            odd_size  <= size_full[0];
                            bank      <= bank_num[BANK_W-1:0];
                            offset    <= '0;
                        end
                    end
                    CHUNK_DATA: begin
                        remaining <= remaining - 32'd1;
                        // Bytes past the bank end are swallowed silently.
                        if (offset < (OFF_W+1)'(BANK_BYTES)) begin
                            mem_req  <= 1'b1;
                            mem_addr <= {bank, offset[OFF_W-1:0]};
                            mem_data <= file_data;
                            offset   <= offset + 1'b1;
                        end
                    end
                    SKIP: remaining <= remaining - 32'd1;
                    default: ;
                endcase
            end
        end
    end
endmodule
